// File: rtl/riscv_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MEMSIZE_W = 5;
  localparam int unsigned STRB_W    = 4;

  // One-hot memsize bit positions: {w,hu,h,bu,b}
  localparam int unsigned MS_B  = 0;
  localparam int unsigned MS_BU = 1;
  localparam int unsigned MS_H  = 2;
  localparam int unsigned MS_HU = 3;
  localparam int unsigned MS_W  = 4;

  localparam logic [XLEN-1:0] MCAUSE_LOAD_MISALIGN  = 32'd4;
  localparam logic [XLEN-1:0] MCAUSE_LOAD_FAULT     = 32'd5;
  localparam logic [XLEN-1:0] MCAUSE_STORE_MISALIGN = 32'd6;
  localparam logic [XLEN-1:0] MCAUSE_STORE_FAULT    = 32'd7;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Store lane steering and strobes, load lane extract/extend, misalignment check.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [MEMSIZE_W-1:0] memsize,
  input  logic [1:0]           addr_lo,
  input  logic [XLEN-1:0]      store_data,
  input  logic [MEMSIZE_W-1:0] load_size,
  input  logic [1:0]           load_off,
  input  logic [XLEN-1:0]      rdata,
  output logic                 misaligned,
  output logic [STRB_W-1:0]    wstrb,
  output logic [XLEN-1:0]      wdata,
  output logic [XLEN-1:0]      load_data
);

  logic is_half;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign is_half    = memsize[MS_H] | memsize[MS_HU];
  assign misaligned = (is_half & addr_lo[0]) | (memsize[MS_W] & (addr_lo != 2'b00));

  always_comb begin
    wstrb = '0;
    wdata = store_data;
    if (memsize[MS_W]) begin
      wstrb = 4'b1111;
    end else if (is_half) begin
      wdata = {2{store_data[15:0]}};
      wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
    end else if (memsize[MS_B] | memsize[MS_BU]) begin
      wdata = {4{store_data[7:0]}};
      wstrb = 4'b0001 << addr_lo;
    end
  end

  assign byte_sel = rdata[{load_off, 3'b000} +: 8];
  assign half_sel = load_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    if (load_size[MS_B])       load_data = {{24{byte_sel[7]}}, byte_sel};
    else if (load_size[MS_BU]) load_data = {24'd0, byte_sel};
    else if (load_size[MS_H])  load_data = {{16{half_sel[15]}}, half_sel};
    else if (load_size[MS_HU]) load_data = {16'd0, half_sel};
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one req/gnt/rvalid transaction per memory instruction,
// with load formatting, misalignment/fault traps and an optional response watchdog.
module mem_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 pipe_adv_i,
  input  logic                 valid_i,
  input  logic                 is_mem_read_i,
  input  logic                 is_mem_write_i,
  input  logic                 trap_valid_i,
  input  logic [MEMSIZE_W-1:0] memsize_i,
  input  logic [XLEN-1:0]      addr_i,
  input  logic [XLEN-1:0]      store_wdata_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [XLEN-1:0]      dmem_addr_o,
  output logic [STRB_W-1:0]    dmem_wstrb_o,
  output logic [XLEN-1:0]      dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [XLEN-1:0]      dmem_rdata_i,
  input  logic                 dmem_err_i,
  output logic                 stall_o,
  output logic                 done_o,
  output logic [XLEN-1:0]      load_data_o,
  output logic                 trap_valid_o,
  output logic [XLEN-1:0]      trap_mcause_o,
  output logic [XLEN-1:0]      trap_mtval_o
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  lsu_state_e state_q, state_d;

  logic                 req_q, we_q, killed_q, done_latched_q, err_q, timeout_q;
  logic [XLEN-1:0]      addr_q, wdata_q, load_data_q;
  logic [STRB_W-1:0]    wstrb_q;
  logic [MEMSIZE_W-1:0] size_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 misaligned_c, mem_op_c, start_c, misalign_trap_c, expire_c;
  logic [STRB_W-1:0]    wstrb_c;
  logic [XLEN-1:0]      wdata_c, load_fmt_c;

  lsu_align u_align (
    .memsize    (memsize_i),
    .addr_lo    (addr_i[1:0]),
    .store_data (store_wdata_i),
    .load_size  (size_q),
    .load_off   (addr_q[1:0]),
    .rdata      (dmem_rdata_i),
    .misaligned (misaligned_c),
    .wstrb      (wstrb_c),
    .wdata      (wdata_c),
    .load_data  (load_fmt_c)
  );

  assign mem_op_c        = valid_i & (is_mem_read_i | is_mem_write_i) & ~trap_valid_i & ~flush_i;
  assign start_c         = (state_q == IDLE) & mem_op_c & ~misaligned_c & ~done_latched_q;
  assign misalign_trap_c = (state_q == IDLE) & mem_op_c & misaligned_c;
  assign expire_c        = (TIMEOUT_CYCLES != 0) & (state_q == WAIT) & ~dmem_rvalid_i
                         & (cnt_q == CNT_W'(TO_LAST));

  // Next state, stall and trap reporting
  always_comb begin
    state_d       = state_q;
    stall_o       = 1'b0;
    done_o        = 1'b0;
    trap_valid_o  = 1'b0;
    trap_mcause_o = '0;
    trap_mtval_o  = '0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = REQ;
          stall_o = 1'b1;
        end else if (misalign_trap_c) begin
          trap_valid_o  = 1'b1;
          trap_mcause_o = is_mem_write_i ? MCAUSE_STORE_MISALIGN : MCAUSE_LOAD_MISALIGN;
          trap_mtval_o  = addr_i;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (dmem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i)  state_d = (killed_q | flush_i) ? IDLE : DONE;
        else if (expire_c)  state_d = (killed_q | flush_i) ? DRAIN : DONE;
      end
      DONE: begin
        done_o = 1'b1;
        if (err_q) begin
          trap_valid_o  = 1'b1;
          trap_mcause_o = we_q ? MCAUSE_STORE_FAULT : MCAUSE_LOAD_FAULT;
          trap_mtval_o  = addr_q;
        end
        state_d = timeout_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wstrb_q        <= '0;
      wdata_q        <= '0;
      size_q         <= '0;
      killed_q       <= 1'b0;
      done_latched_q <= 1'b0;
      err_q          <= 1'b0;
      timeout_q      <= 1'b0;
      cnt_q          <= '0;
      load_data_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_c) begin
        req_q     <= 1'b1;
        we_q      <= is_mem_write_i;
        addr_q    <= addr_i;
        wstrb_q   <= is_mem_write_i ? wstrb_c : '0;
        wdata_q   <= is_mem_write_i ? wdata_c : '0;
        size_q    <= memsize_i;
        killed_q  <= 1'b0;
        err_q     <= 1'b0;
        timeout_q <= 1'b0;
      end
      if ((state_q == REQ) && dmem_gnt_i) begin
        req_q <= 1'b0;
        cnt_q <= '0;
      end
      // A flushed access stays on the bus until its response, but is never reported
      if (((state_q == REQ) || (state_q == WAIT)) && flush_i) killed_q <= 1'b1;
      if (state_q == WAIT) begin
        if (dmem_rvalid_i) begin
          err_q <= dmem_err_i;
          if (!we_q && !killed_q && !flush_i) load_data_q <= load_fmt_c;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (expire_c) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
      end
      // Blocks re-issue of an instruction still held in EX/MEM after completing
      if ((state_q == DONE) && !pipe_adv_i && !flush_i) done_latched_q <= 1'b1;
      else if (pipe_adv_i || flush_i)                   done_latched_q <= 1'b0;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem_wstrb_o = wstrb_q;
  assign dmem_wdata_o = wdata_q;
  assign load_data_o  = load_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed scoreboard bench for mem_lsu (watchdog enabled at 4 cycles).
module tb_mem_lsu;

  localparam logic [4:0] SZ_B  = 5'b00001;
  localparam logic [4:0] SZ_BU = 5'b00010;
  localparam logic [4:0] SZ_H  = 5'b00100;
  localparam logic [4:0] SZ_HU = 5'b01000;
  localparam logic [4:0] SZ_W  = 5'b10000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i, pipe_adv_i, valid_i, is_mem_read_i, is_mem_write_i, trap_valid_i;
  logic [4:0]  memsize_i;
  logic [31:0] addr_i, store_wdata_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_wstrb_o;
  logic        dmem_gnt_i, dmem_rvalid_i, dmem_err_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o, done_o, trap_valid_o;
  logic [31:0] load_data_o, trap_mcause_o, trap_mtval_o;

  typedef struct {
    logic        is_load;
    logic [31:0] data;
    logic        trap;
    logic [31:0] mcause;
    logic [31:0] mtval;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .pipe_adv_i(pipe_adv_i),
    .valid_i(valid_i), .is_mem_read_i(is_mem_read_i), .is_mem_write_i(is_mem_write_i),
    .trap_valid_i(trap_valid_i), .memsize_i(memsize_i), .addr_i(addr_i),
    .store_wdata_i(store_wdata_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wstrb_o(dmem_wstrb_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .dmem_err_i(dmem_err_i), .stall_o(stall_o), .done_o(done_o), .load_data_o(load_data_o),
    .trap_valid_o(trap_valid_o), .trap_mcause_o(trap_mcause_o), .trap_mtval_o(trap_mtval_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference load formatting: shift the addressed lane down, then extend
  function automatic logic [31:0] ref_load(input logic [4:0] sz, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> {a[1:0], 3'b000};
    case (sz)
      SZ_B:    return {{24{s[7]}}, s[7:0]};
      SZ_BU:   return {24'h0, s[7:0]};
      SZ_H:    return {{16{s[15]}}, s[15:0]};
      SZ_HU:   return {16'h0, s[15:0]};
      default: return rd;
    endcase
  endfunction

  // Compare the completion cycle against the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && done_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("done_without_pending", 32'(done_o), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_trap_valid", 32'(trap_valid_o), 32'(mon_e.trap));
        if (mon_e.trap) begin
          chk("done_mcause", trap_mcause_o, mon_e.mcause);
          chk("done_mtval", trap_mtval_o, mon_e.mtval);
        end else if (mon_e.is_load) begin
          chk("done_load_data", load_data_o, mon_e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic wr, input logic [4:0] sz, input logic [31:0] a,
                          input logic [31:0] rd, input logic err);
    exp_t e;
    e.is_load = !wr;
    e.data    = ref_load(sz, a, rd);
    e.trap    = err;
    e.mcause  = wr ? 32'd7 : 32'd5;
    e.mtval   = a;
    sb.push_back(e);
  endtask

  task automatic drive_op(input logic wr, input logic [4:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
    valid_i = 1'b1; is_mem_read_i = !wr; is_mem_write_i = wr;
    memsize_i = sz; addr_i = a; store_wdata_i = wd;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; is_mem_read_i = 1'b0; is_mem_write_i = 1'b0;
  endtask

  // One full access with gnt after gnt_dly REQ cycles and rvalid in the first WAIT cycle
  task automatic access(input logic wr, input logic [4:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int gnt_dly, input logic [31:0] rd,
                        input logic err, input logic [31:0] exp_wd, input logic [3:0] exp_strb);
    push_exp(wr, sz, a, rd, err);
    drive_op(wr, sz, a, wd);
    #1;
    chk("start_stall", 32'(stall_o), 32'd1);
    chk("start_no_req", 32'(dmem_req_o), 32'd0);
    for (int i = 0; i <= gnt_dly; i++) begin
      tick();
      dmem_gnt_i = (i == gnt_dly);
      #1;
      chk("req", 32'(dmem_req_o), 32'd1);
      chk("req_we", 32'(dmem_we_o), 32'(wr));
      chk("req_addr", dmem_addr_o, {a[31:2], 2'b00});
      chk("req_stall", 32'(stall_o), 32'd1);
      if (wr) begin
        chk("req_wstrb", 32'(dmem_wstrb_o), 32'(exp_strb));
        chk("req_wdata", dmem_wdata_o, exp_wd);
      end
    end
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = rd; dmem_err_i = err;
    #1;
    chk("wait_stall", 32'(stall_o), 32'd1);
    chk("wait_no_req", 32'(dmem_req_o), 32'd0);
    tick();
    dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0; pipe_adv_i = 1'b1;
    #1;
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("done_stall", 32'(stall_o), 32'd0);
    tick();
    pipe_adv_i = 1'b0;
    idle_inputs();
    #1;
    chk("after_done", 32'(done_o), 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; pipe_adv_i = 1'b0; trap_valid_i = 1'b0;
    idle_inputs();
    memsize_i = '0; addr_i = '0; store_wdata_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0; dmem_err_i = 1'b0;
    repeat (3) tick();
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_we", 32'(dmem_we_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_load_data", load_data_o, 32'd0);
    chk("rst_trap", 32'(trap_valid_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // lb from the top byte: sign extension
    access(1'b0, SZ_B, 32'h0000_1003, 32'h0, 0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
    chk("lb_value_held", load_data_o, 32'hFFFF_FF80);
    // sh to upper half with a 5-cycle grant delay
    access(1'b1, SZ_H, 32'h0000_2002, 32'h0000_BEEF, 5, 32'h0, 1'b0, 32'hBEEF_BEEF, 4'b1100);
    // sb lane steering, lh/lbu/hu extraction
    access(1'b1, SZ_B, 32'h0000_2101, 32'h0000_00A5, 1, 32'h0, 1'b0, 32'hA5A5_A5A5, 4'b0010);
    access(1'b1, SZ_W, 32'h0000_2200, 32'h1234_5678, 0, 32'h0, 1'b0, 32'h1234_5678, 4'b1111);
    access(1'b0, SZ_H, 32'h0000_7002, 32'h0, 0, 32'h8001_1234, 1'b0, 32'h0, 4'h0);
    access(1'b0, SZ_BU, 32'h0000_7001, 32'h0, 2, 32'h00FF_AB00, 1'b0, 32'h0, 4'h0);
    access(1'b0, SZ_HU, 32'h0000_7002, 32'h0, 0, 32'hF00D_0000, 1'b0, 32'h0, 4'h0);

    // Misaligned lw and sh: immediate trap, no request
    drive_op(1'b0, SZ_W, 32'h0000_3001, 32'h0);
    #1;
    chk("mis_lw_trap", 32'(trap_valid_o), 32'd1);
    chk("mis_lw_mcause", trap_mcause_o, 32'd4);
    chk("mis_lw_mtval", trap_mtval_o, 32'h0000_3001);
    chk("mis_lw_stall", 32'(stall_o), 32'd0);
    tick();
    chk("mis_lw_no_req", 32'(dmem_req_o), 32'd0);
    drive_op(1'b1, SZ_H, 32'h0000_2001, 32'h0);
    #1;
    chk("mis_sh_mcause", trap_mcause_o, 32'd6);
    chk("mis_sh_stall", 32'(stall_o), 32'd0);
    tick();
    idle_inputs();
    chk("mis_sh_no_req", 32'(dmem_req_o), 32'd0);

    // lhu with bus error
    access(1'b0, SZ_HU, 32'h0000_4000, 32'h0, 0, 32'h5555_5555, 1'b1, 32'h0, 4'h0);

    // lw flushed in WAIT, response two cycles later
    drive_op(1'b0, SZ_W, 32'h0000_5000, 32'h0);
    #1;
    chk("fl_start_stall", 32'(stall_o), 32'd1);
    tick(); dmem_gnt_i = 1'b1;
    tick(); dmem_gnt_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("fl_w1_stall", 32'(stall_o), 32'd1);
    tick(); flush_i = 1'b0; idle_inputs();
    #1;
    chk("fl_w2_stall", 32'(stall_o), 32'd1);
    tick(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
    #1;
    chk("fl_w3_stall", 32'(stall_o), 32'd1);
    chk("fl_w3_trap", 32'(trap_valid_o), 32'd0);
    tick(); dmem_rvalid_i = 1'b0;
    #1;
    chk("fl_idle_stall", 32'(stall_o), 32'd0);
    chk("fl_idle_done", 32'(done_o), 32'd0);
    access(1'b0, SZ_W, 32'h0000_5004, 32'h0, 0, 32'h1234_5678, 1'b0, 32'h0, 4'h0);

    // Watchdog: no rvalid for 4 WAIT cycles
    push_exp(1'b0, SZ_W, 32'h0000_6000, 32'h0, 1'b1);
    drive_op(1'b0, SZ_W, 32'h0000_6000, 32'h0);
    tick(); dmem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); dmem_gnt_i = 1'b0;
      #1;
      chk("to_wait_stall", 32'(stall_o), 32'd1);
      chk("to_wait_no_done", 32'(done_o), 32'd0);
    end
    tick();
    #1;
    chk("to_done", 32'(done_o), 32'd1);
    chk("to_mcause", trap_mcause_o, 32'd5);
    tick();
    #1;
    chk("to_drain1_stall", 32'(stall_o), 32'd1);
    tick(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("to_drain2_stall", 32'(stall_o), 32'd1);
    tick(); dmem_rvalid_i = 1'b0;
    #1;
    chk("to_latched_stall", 32'(stall_o), 32'd0);
    tick();
    chk("to_latched_no_req", 32'(dmem_req_o), 32'd0);
    chk("to_load_data_kept", load_data_o, 32'h1234_5678);
    pipe_adv_i = 1'b1;
    #1;
    chk("to_adv_stall", 32'(stall_o), 32'd0);
    tick(); pipe_adv_i = 1'b0; idle_inputs();
    access(1'b0, SZ_W, 32'h0000_6004, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 32'h0, 4'h0);

    repeat (2) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit of the MEM stage. Sits directly downstream of the EX/MEM pipeline register and consumes its mem_q_* outputs.
- Issues one data-memory transaction per memory instruction over a req/gnt/rvalid bus, formats load data and detects misaligned or faulting accesses.
- Drives the stall that holds the EX/MEM register while an access is outstanding.

Parameters:
TIMEOUT_CYCLES, 0, cycles to wait for rvalid after gnt before raising an access fault; 0 disables the watchdog.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  kill instruction in MEM (same signal as ex_mem_flush)
pipe_adv_i  in  1  EX/MEM register loads a new instruction this cycle
valid_i  in  1  mem_q_valid
is_mem_read_i  in  1  load
is_mem_write_i  in  1  store
trap_valid_i  in  1  instruction already trapped upstream; no access
memsize_i  in  5  one-hot {w,hu,h,bu,b}
addr_i  in  32  effective address (mem_q_alu_csr_result)
store_wdata_i  in  32  rs2 value
dmem_req_o  out  1  bus request
dmem_we_o  out  1  write enable
dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wstrb_o  out  4  byte strobes
dmem_wdata_o  out  32  lane-aligned write data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  response valid (loads and stores)
dmem_rdata_i  in  32  read data
dmem_err_i  in  1  bus error, qualified by rvalid
stall_o  out  1  hold EX/MEM and upstream
done_o  out  1  one-cycle pulse, access completed
load_data_o  out  32  extended load result, held until next done_o
trap_valid_o  out  1  LSU exception
trap_mcause_o  out  32  4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault
trap_mtval_o  out  32  faulting address

Behaviour:
- Reset (async, rst_ni low): state IDLE, all registered outputs 0, killed and done_latched flags 0, watchdog counter 0. Reset mid-transaction abandons it; the bus is reset by the same signal.
- start = IDLE & valid_i & (is_mem_read_i|is_mem_write_i) & !trap_valid_i & aligned & !done_latched & !flush_i.
- Misalignment: h/hu with addr[0]=1; w with addr[1:0]!=0. In IDLE this combinationally gives trap_valid_o=1, mcause 4/6, mtval=addr_i. No request issues and stall_o stays 0.
- FSM:
  - IDLE: start -> REQ. stall_o=1 in the start cycle.
  - REQ: dmem_req_o=1, held with stable addr/we/wstrb/wdata until gnt. gnt -> WAIT, counter cleared.
  - WAIT: rvalid -> DONE, capturing rdata/err. Counter expiry (TIMEOUT_CYCLES>0) -> DONE with fault and killed_rsp=1, then DRAIN.
  - DONE: done_o=1, load_data_o updated (registered); stall_o=0. If err: trap_valid_o=1, mcause 5/7. Then -> IDLE, or DRAIN if a timeout is pending. Set done_latched unless pipe_adv_i.
  - DRAIN: stall_o=1, wait for the late rvalid and discard it -> IDLE.
- stall_o = start | REQ | WAIT | DRAIN.
- done_latched clears on pipe_adv_i or flush_i. It prevents re-issuing a held instruction.
- Flush in REQ: request is still held until gnt (no retraction), killed=1. Flush in WAIT: killed=1. A killed access never raises done_o or a trap. stall_o stays high until its rvalid, then IDLE.
- Flush and rvalid in the same cycle: response discarded, -> IDLE.
- Store formatting:
  - sb: wdata = {4{byte}}, wstrb = 1<<addr[1:0].
  - sh: wdata = {2{half}}, wstrb = addr[1] ? 1100 : 0011.
  - sw: wstrb = 1111.
- Load formatting: select lane by addr[1:0] registered at issue. b/h sign-extend; bu/hu zero-extend.
- Latency: minimum 3 cycles (start, REQ with gnt, WAIT with rvalid), with done_o on the 4th.

Decomposition:
- riscv_pkg gets lsu_state_e (IDLE, REQ, WAIT, DONE, DRAIN), MCAUSE_LOAD_MISALIGN/LOAD_FAULT/STORE_MISALIGN/STORE_FAULT constants, and the memsize one-hot index constants.
- One combinational sub-module, lsu_align: store lane steering/strobes, load extract/extend and the misalignment check.

Test Plan:
- lb, addr 0x1003, rdata 0x80_00_00_00, gnt and rvalid immediate -> req with addr 0x1000, we=0; done_o on the 4th cycle; load_data_o 0xFFFFFF80; stall_o high for 3 cycles.
- sh, addr 0x2002, rs2 0x0000BEEF, gnt delayed 5 cycles -> req held stable 6 cycles; wdata 0xBEEFBEEF, wstrb 1100; done_o after rvalid.
- lw, addr 0x3001 -> no req; trap_valid_o=1 same cycle, mcause 4, mtval 0x3001, stall_o=0.
- lhu, rvalid with err=1, addr 0x4000 -> done_o with trap mcause 5, mtval 0x4000.
- lw issued, flush_i in WAIT, rvalid 2 cycles later -> no done_o, no trap; stall_o high until rvalid, then IDLE; next lw issues normally.
- TIMEOUT_CYCLES=4, gnt then no rvalid -> fault mcause 5 after 4 WAIT cycles; DRAIN swallows the late rvalid; done_latched blocks re-issue until pipe_adv_i.
